// File: rtl/pc_sequencer.sv
// IF-stage fetch sequencer: chooses the next PC address and PC load enable,
// handling redirects, hazard stalls, HALT detection and debug single-step.
module pc_sequencer #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}},
   parameter logic [31:0]           HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] pc_current,
   input  logic [31:0]           instr,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump_taken,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic                  mode_step,
   input  logic                  step_req,
   input  logic                  resume,
   output logic [ADDR_WIDTH-1:0] pc_next,
   output logic                  pc_enable,
   output logic                  flush_if,
   output logic                  halted,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      STEP_WAIT = 2'd1,
      STEP_GO   = 2'd2,
      HALTED    = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic                    step_prev_r;
   logic                    halted_r;
   logic [31:0]             fetch_count_r;
   logic [ADDR_WIDTH-1:0]   seq_addr_s;
   logic [ADDR_WIDTH-1:0]   mux_addr_s;
   logic                    redirect_s;
   logic                    step_edge_s;
   logic                    is_halt_s;

   // A stalled redirect is not consumed, so it neither flushes nor masks HALT.
   assign seq_addr_s  = pc_current + ADDR_WIDTH'(4);
   assign redirect_s  = (jump_taken | branch_taken) & ~stall;
   assign step_edge_s = step_req & ~step_prev_r;
   assign is_halt_s   = (instr == HALT_INSTR) & ~redirect_s;

   // Next-address priority mux: jump over branch over sequential.
   always_comb begin
      mux_addr_s = seq_addr_s;
      if (jump_taken) begin
         mux_addr_s = jump_target;
      end else if (branch_taken) begin
         mux_addr_s = branch_target;
      end else begin
         mux_addr_s = seq_addr_s;
      end
   end

   // State register and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= RUN;
         step_prev_r   <= 1'b0;
         halted_r      <= 1'b0;
         fetch_count_r <= 32'd0;
      end else begin
         state_r     <= state_s;
         step_prev_r <= step_req;
         halted_r    <= (state_s == HALTED);
         if (pc_enable) begin
            fetch_count_r <= fetch_count_r + 32'd1;
         end else begin
            fetch_count_r <= fetch_count_r;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         RUN: begin
            if (mode_step) begin
               state_s = STEP_WAIT;
            end else if (is_halt_s && !stall) begin
               state_s = HALTED;
            end else begin
               state_s = RUN;
            end
         end
         STEP_WAIT: begin
            if (!mode_step) begin
               state_s = RUN;
            end else if (is_halt_s) begin
               state_s = HALTED;
            end else if (step_edge_s) begin
               state_s = STEP_GO;
            end else begin
               state_s = STEP_WAIT;
            end
         end
         STEP_GO: begin
            if (is_halt_s) begin
               state_s = HALTED;
            end else if (!stall) begin
               state_s = STEP_WAIT;
            end else begin
               state_s = STEP_GO;
            end
         end
         HALTED: begin
            if (resume) begin
               state_s = mode_step ? STEP_WAIT : RUN;
            end else begin
               state_s = HALTED;
            end
         end
         default: state_s = RUN;
      endcase
   end

   // Output logic; reset forces a load of RESET_ADDR into the PC.
   always_comb begin
      pc_next   = mux_addr_s;
      pc_enable = 1'b0;
      flush_if  = 1'b0;
      if (!rst_n) begin
         pc_next   = RESET_ADDR;
         pc_enable = 1'b1;
         flush_if  = 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               if (mode_step || (is_halt_s && !stall)) begin
                  pc_enable = 1'b0;
               end else begin
                  pc_enable = ~stall;
                  flush_if  = redirect_s;
               end
            end
            STEP_WAIT: pc_enable = 1'b0;
            STEP_GO: begin
               if (is_halt_s) begin
                  pc_enable = 1'b0;
               end else begin
                  pc_enable = ~stall;
                  flush_if  = redirect_s;
               end
            end
            HALTED: begin
               // Resume steps past the HALT word; pending redirects are ignored.
               if (resume) begin
                  pc_enable = 1'b1;
                  pc_next   = seq_addr_s;
               end else begin
                  pc_enable = 1'b0;
               end
            end
            default: pc_enable = 1'b0;
         endcase
      end
   end

   assign halted      = halted_r;
   assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with a behavioural PC register
// and a tiny instruction source that returns HALT at one chosen address.
module tb_pc_sequencer;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam int K_NEXT = 0, K_EN = 1, K_FL = 2, K_HLT = 3, K_FC = 4, K_PC = 5;

   logic        clk = 1'b0;
   logic        rst_n, stall, branch_taken, jump_taken, mode_step, step_req, resume;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_q, halt_at, instr, pc_next, fetch_count, nxt;
   logic        pc_enable, flush_if, halted;

   typedef struct { string tag; int kind; logic [31:0] val; } exp_t;
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   assign instr = (pc_q == halt_at) ? HALT : NOP;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .pc_current(pc_q), .instr(instr), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump_taken(jump_taken), .jump_target(jump_target),
      .mode_step(mode_step), .step_req(step_req), .resume(resume),
      .pc_next(pc_next), .pc_enable(pc_enable), .flush_if(flush_if),
      .halted(halted), .fetch_count(fetch_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_NEXT:  return pc_next;
         K_EN:    return {31'd0, pc_enable};
         K_FL:    return {31'd0, flush_if};
         K_HLT:   return {31'd0, halted};
         K_FC:    return fetch_count;
         default: return pc_q;
      endcase
   endfunction

   task automatic ex(input string tag, input int kind, input logic [31:0] v);
      sb.push_back('{tag, kind, v});
   endtask

   task automatic drain();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.kind), e.val);
      end
   endtask

   // Behavioural PC register: loads pc_next on the edge when enabled.
   task automatic tick();
      #1;
      nxt = pc_enable ? pc_next : pc_q;
      @(posedge clk);
      #1;
      pc_q = nxt;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
      mode_step = 1'b0; step_req = 1'b0; resume = 1'b0;
      branch_target = 32'd0; jump_target = 32'd0;
      pc_q = 32'hDEAD_BEE0; halt_at = 32'd1;
      @(posedge clk); #1;

      // Reset held for two cycles
      ex("rst_next", K_NEXT, 32'd0); ex("rst_en", K_EN, 32'd1); ex("rst_flush", K_FL, 32'd1);
      drain(); tick();
      ex("rst_fc", K_FC, 32'd0); ex("rst_halted", K_HLT, 32'd0); ex("rst_pc", K_PC, 32'd0);
      drain(); tick();
      rst_n = 1'b1;

      // Free run 0,4,8,12
      for (int i = 0; i < 4; i++) begin
         ex("run_pc", K_PC, 32'(4 * i)); ex("run_next", K_NEXT, 32'(4 * i + 4));
         ex("run_en", K_EN, 32'd1); ex("run_flush", K_FL, 32'd0); ex("run_fc", K_FC, 32'(i));
         drain(); tick();
      end

      // Jump beats branch at pc 0x10, then branch alone
      jump_taken = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
      ex("jb_pc", K_PC, 32'h10); ex("jb_next", K_NEXT, 32'h100); ex("jb_flush", K_FL, 32'd1);
      drain();
      jump_taken = 1'b0;
      ex("br_next", K_NEXT, 32'h200); ex("br_flush", K_FL, 32'd1); ex("br_en", K_EN, 32'd1);
      drain(); tick();

      // Stalled branch holds the PC, taken once the stall drops
      branch_target = 32'h40; stall = 1'b1;
      ex("stl_en", K_EN, 32'd0); ex("stl_flush", K_FL, 32'd0);
      drain(); tick();
      stall = 1'b0;
      ex("stl_pc", K_PC, 32'h200); ex("stl_fc", K_FC, 32'd5);
      ex("unstl_next", K_NEXT, 32'h40); ex("unstl_en", K_EN, 32'd1); ex("unstl_flush", K_FL, 32'd1);
      drain(); tick();
      branch_taken = 1'b0;

      // HALT word fetched alongside a jump is wrong-path: no halt
      halt_at = 32'h40; jump_taken = 1'b1; jump_target = 32'h20;
      ex("hj_en", K_EN, 32'd1); ex("hj_next", K_NEXT, 32'h20); ex("hj_flush", K_FL, 32'd1);
      drain(); tick();
      jump_taken = 1'b0; halt_at = 32'h20;
      ex("hj_halted", K_HLT, 32'd0); ex("hj_pc", K_PC, 32'h20);
      ex("halt_en", K_EN, 32'd0); ex("halt_flush", K_FL, 32'd0);
      drain(); tick();
      for (int i = 0; i < 10; i++) begin
         ex("hlt_halted", K_HLT, 32'd1); ex("hlt_pc", K_PC, 32'h20);
         ex("hlt_en", K_EN, 32'd0); ex("hlt_fc", K_FC, 32'd7); ex("hlt_flush", K_FL, 32'd0);
         drain(); tick();
      end
      resume = 1'b1;
      ex("res_en", K_EN, 32'd1); ex("res_next", K_NEXT, 32'h24);
      drain(); tick();
      resume = 1'b0; halt_at = 32'd1;
      ex("res_pc", K_PC, 32'h24); ex("res_halted", K_HLT, 32'd0); ex("res_fc", K_FC, 32'd8);
      drain();

      // Single-step: mode_step holds, held step_req gives one advance
      mode_step = 1'b1;
      ex("sm_en", K_EN, 32'd0); ex("sm_flush", K_FL, 32'd0);
      drain(); tick();
      ex("sw_en", K_EN, 32'd0); drain(); tick();
      step_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ex("hold_en", K_EN, (i == 1) ? 32'd1 : 32'd0);
         drain(); tick();
      end
      ex("step1_pc", K_PC, 32'h28); ex("step1_fc", K_FC, 32'd9);
      drain();
      step_req = 1'b0; tick();
      step_req = 1'b1;
      ex("edge2_en", K_EN, 32'd0); drain(); tick();
      ex("go2_en", K_EN, 32'd1); ex("go2_next", K_NEXT, 32'h2C); drain(); tick();
      ex("step2_pc", K_PC, 32'h2C);
      drain();

      // Step edge arriving under a three-cycle stall
      step_req = 1'b0; tick();
      step_req = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex("sst_en", K_EN, 32'd0); drain(); tick();
      end
      stall = 1'b0;
      ex("sst_go_en", K_EN, 32'd1); ex("sst_go_next", K_NEXT, 32'h30); drain(); tick();
      ex("sst_pc", K_PC, 32'h30); ex("sst_fc", K_FC, 32'd11); ex("sst_after_en", K_EN, 32'd0);
      drain();

      // Reset while in STEP_GO
      step_req = 1'b0; tick();
      step_req = 1'b1; tick();
      rst_n = 1'b0; stall = 1'b1;
      ex("rgo_next", K_NEXT, 32'd0); ex("rgo_en", K_EN, 32'd1); ex("rgo_flush", K_FL, 32'd1);
      drain(); tick();
      rst_n = 1'b1; stall = 1'b0;
      ex("rgo_pc", K_PC, 32'd0); ex("rgo_fc", K_FC, 32'd0); ex("rgo_run_en", K_EN, 32'd0);
      drain(); tick();
      mode_step = 1'b0; step_req = 1'b0;
      ex("rgo_wait_en", K_EN, 32'd0); drain(); tick();
      ex("rgo_free_en", K_EN, 32'd1); drain(); tick();

      // Reset while HALTED
      halt_at = 32'd4;
      ex("rh_pc", K_PC, 32'd4); ex("rh_fc", K_FC, 32'd1); ex("rh_en", K_EN, 32'd0);
      drain(); tick();
      ex("rh_halted", K_HLT, 32'd1); drain();
      rst_n = 1'b0;
      ex("rh_rst_en", K_EN, 32'd1); ex("rh_rst_next", K_NEXT, 32'd0);
      drain(); tick();
      rst_n = 1'b1; halt_at = 32'd1;
      ex("rh_after_halted", K_HLT, 32'd0); ex("rh_after_fc", K_FC, 32'd0);
      ex("rh_after_pc", K_PC, 32'd0); ex("rh_after_en", K_EN, 32'd1);
      drain(); tick();

      // Sequential wrap at the top of the address space
      pc_q = 32'hFFFF_FFFC;
      ex("wrap_next", K_NEXT, 32'd0); ex("wrap_en", K_EN, 32'd1);
      drain(); tick();
      ex("wrap_pc", K_PC, 32'd0); ex("wrap_fc", K_FC, 32'd2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
